// File: rtl/store_merge_buffer_pkg.sv
// Shared types for the store-side write path: write mask, per-entry store record and drain FSM states.
package store_merge_buffer_pkg;
  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_wmask;

  localparam lc3b_wmask WMASK_LO   = 2'b01;
  localparam lc3b_wmask WMASK_HI   = 2'b10;
  localparam lc3b_wmask WMASK_WORD = 2'b11;

  typedef struct packed {
    lc3b_word  addr;
    lc3b_word  data;
    lc3b_wmask mask;
  } lc3b_store_entry;

  typedef enum logic {ST_IDLE = 1'b0, ST_WRITE = 1'b1} store_state_t;
endpackage

// File: rtl/store_merge_buffer_formatter.sv
// Turns a raw STW/STB request into an aligned word write with byte enables.
module store_formatter
  import store_merge_buffer_pkg::*;
(
  input  lc3b_word        i_addr,
  input  lc3b_word        i_data,
  input  logic            i_byte,
  output lc3b_store_entry o_entry
);
  always_comb begin
    // Word stores to odd addresses are force-aligned, never split.
    o_entry.addr = {i_addr[15:1], 1'b0};
    if (i_byte) begin
      o_entry.data = {i_data[7:0], i_data[7:0]};
      o_entry.mask = i_addr[0] ? WMASK_HI : WMASK_LO;
    end else begin
      o_entry.data = i_data;
      o_entry.mask = WMASK_WORD;
    end
  end
endmodule

// File: rtl/store_merge_buffer.sv
// Circular store buffer draining formatted word writes to the dcache, with load-vs-pending-store detect.
module store_merge_buffer
  import store_merge_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [15:0] st_addr,
  input  logic [15:0] st_data,
  input  logic        st_byte,
  output logic        dcache_write,
  output logic [15:0] dcache_address,
  output logic [15:0] dcache_wdata,
  output logic [1:0]  dcache_wmask,
  input  logic        dcache_resp,
  input  logic        ld_valid,
  input  logic [15:0] ld_addr,
  output logic        ld_conflict,
  output logic        buf_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  lc3b_store_entry r_mem [DEPTH];
  logic [PW-1:0]   r_head, r_tail;
  logic [CW-1:0]   r_count, w_count_nxt;
  store_state_t    r_state;
  lc3b_store_entry w_fmt, w_head;
  logic            w_push, w_pop;
  logic [DEPTH-1:0] w_match;

  store_formatter u_fmt (
    .i_addr  (st_addr),
    .i_data  (st_data),
    .i_byte  (st_byte),
    .o_entry (w_fmt)
  );

  // Full blocks accepts even when a pop lands on the same edge.
  assign st_ready  = (r_count != CW'(DEPTH));
  assign buf_empty = (r_count == '0);
  assign w_push    = st_valid && st_ready;
  assign w_pop     = (r_state == ST_WRITE) && dcache_resp;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_state <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= w_fmt;
        r_tail        <= r_tail + PW'(1);
      end
      if (w_pop) r_head <= r_head + PW'(1);
      r_count <= w_count_nxt;
      case (r_state)
        ST_IDLE:  if (r_count != '0) r_state <= ST_WRITE;
        ST_WRITE: if (w_pop && (w_count_nxt == '0)) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_head         = r_mem[r_head];
  assign dcache_write   = (r_state == ST_WRITE);
  assign dcache_address = dcache_write ? w_head.addr : '0;
  assign dcache_wdata   = dcache_write ? w_head.data : '0;
  assign dcache_wmask   = dcache_write ? w_head.mask : '0;

  // An entry is live when its distance from head is below count; the head stays live until popped.
  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    logic [PW-1:0] w_dist;
    assign w_dist     = PW'(g) - r_head;
    assign w_match[g] = ({1'b0, w_dist} < r_count) && (r_mem[g].addr[15:1] == ld_addr[15:1]);
  end

  assign ld_conflict = ld_valid && (|w_match);
endmodule

// File: tb/tb_store_merge_buffer.sv
// Scenario bench for store_merge_buffer: accepted stores are modelled into a queue, drained writes are compared.
module tb_store_merge_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0, st_byte = 1'b0;
  logic [15:0] st_addr = '0, st_data = '0;
  logic        st_ready;
  logic        dcache_write, dcache_resp = 1'b0;
  logic [15:0] dcache_address, dcache_wdata;
  logic [1:0]  dcache_wmask;
  logic        ld_valid = 1'b0;
  logic [15:0] ld_addr = '0;
  logic        ld_conflict, buf_empty;

  always #5 clk = ~clk;

  store_merge_buffer #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_byte(st_byte),
    .dcache_write(dcache_write), .dcache_address(dcache_address),
    .dcache_wdata(dcache_wdata), .dcache_wmask(dcache_wmask),
    .dcache_resp(dcache_resp), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_conflict(ld_conflict), .buf_empty(buf_empty)
  );

  typedef struct { logic [15:0] a; logic [15:0] d; logic [1:0] m; } exp_t;
  exp_t sb[$];
  int vec = 0, errs = 0;

  function automatic exp_t model(logic [15:0] a, logic [15:0] d, logic b);
    exp_t e;
    e.a = a & 16'hFFFE;
    if (b) begin e.d = {d[7:0], d[7:0]}; e.m = a[0] ? 2'b10 : 2'b01; end
    else   begin e.d = d; e.m = 2'b11; end
    return e;
  endfunction

  // Expected writes enter the scoreboard at the accepting edge.
  always @(posedge clk) if (rst_n && st_valid && st_ready) sb.push_back(model(st_addr, st_data, st_byte));

  task automatic set_store(input logic [15:0] a, input logic [15:0] d, input logic b);
    st_valid = 1'b1; st_addr = a; st_data = d; st_byte = b;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ld_valid = 1'b1; ld_addr = 16'h0000;
    repeat (2) @(negedge clk);
    vec++; if ({dcache_write, st_ready, buf_empty, ld_conflict} !== 4'b0110) begin
      errs++; $display("FAIL reset_flags got=%b want=0110", {dcache_write, st_ready, buf_empty, ld_conflict}); end
    vec++; if ({dcache_address, dcache_wdata, dcache_wmask} !== 34'h0) begin
      errs++; $display("FAIL reset_outputs got=%h/%h/%b want=0", dcache_address, dcache_wdata, dcache_wmask); end
    tick(); rst_n = 1'b1; ld_valid = 1'b0;
  endtask

  task automatic test_stb_basic();
    set_store(16'h3001, 16'h12AB, 1'b1);
    tick(); st_valid = 1'b0;
    @(negedge clk);
    vec++; if (dcache_write !== 1'b0 || buf_empty !== 1'b0) begin
      errs++; $display("FAIL stb_edge_k got write=%b empty=%b want 0/0", dcache_write, buf_empty); end
    @(negedge clk);
    vec++; if (dcache_write !== 1'b1) begin
      errs++; $display("FAIL stb_edge_k1 got write=%b want 1", dcache_write); end
    vec++; if ({dcache_address, dcache_wdata, dcache_wmask} !== {16'h3000, 16'hABAB, 2'b10}) begin
      errs++; $display("FAIL stb_format got=%h/%h/%b want=3000/abab/10", dcache_address, dcache_wdata, dcache_wmask); end
    repeat (2) @(negedge clk);
    vec++; if (sb.size() != 1 || dcache_write !== 1'b1 ||
               {dcache_address, dcache_wdata, dcache_wmask} !== {sb[0].a, sb[0].d, sb[0].m}) begin
      errs++; $display("FAIL stb_hold got write=%b %h/%h/%b", dcache_write, dcache_address, dcache_wdata, dcache_wmask); end
    tick(); dcache_resp = 1'b1;
    tick(); dcache_resp = 1'b0; if (sb.size() != 0) sb.pop_front();
    @(negedge clk);
    vec++; if (buf_empty !== 1'b1 || dcache_write !== 1'b0) begin
      errs++; $display("FAIL stb_drained got empty=%b write=%b want 1/0", buf_empty, dcache_write); end
  endtask

  task automatic test_back_to_back();
    set_store(16'h4000, 16'hBEEF, 1'b0); tick();
    set_store(16'h4002, 16'h0055, 1'b1); tick();
    set_store(16'h4004, 16'h1234, 1'b0);
    @(negedge clk);
    vec++; if (st_ready !== 1'b0 || dcache_write !== 1'b1) begin
      errs++; $display("FAIL b2b_full got ready=%b write=%b want 0/1", st_ready, dcache_write); end
    tick(); st_valid = 1'b0;
    vec++; if (sb.size() != 2) begin
      errs++; $display("FAIL b2b_accepts got=%0d want=2", sb.size()); end
    for (int n = 0; n < 2; n++) begin
      int t = 0;
      @(negedge clk);
      while (!dcache_write && t < 8) begin @(negedge clk); t++; end
      vec++;
      if (!dcache_write || sb.size() == 0) begin
        errs++; $display("FAIL b2b_write%0d timeout write=%b queued=%0d", n, dcache_write, sb.size()); end
      else if ({dcache_address, dcache_wdata, dcache_wmask} !== {sb[0].a, sb[0].d, sb[0].m}) begin
        errs++; $display("FAIL b2b_write%0d got=%h/%h/%b want=%h/%h/%b", n, dcache_address, dcache_wdata,
                         dcache_wmask, sb[0].a, sb[0].d, sb[0].m); end
      tick(); dcache_resp = 1'b1;
      tick(); dcache_resp = 1'b0; if (sb.size() != 0) sb.pop_front();
    end
    @(negedge clk);
    vec++; if (buf_empty !== 1'b1) begin
      errs++; $display("FAIL b2b_empty got=%b want=1", buf_empty); end
  endtask

  task automatic test_full_pop_push();
    set_store(16'h7000, 16'h1111, 1'b0); tick();
    set_store(16'h7002, 16'h2222, 1'b0); tick();
    st_valid = 1'b0;
    tick();
    set_store(16'h7004, 16'h3333, 1'b0); dcache_resp = 1'b1;
    @(negedge clk);
    vec++; if (st_ready !== 1'b0 || dcache_address !== 16'h7000) begin
      errs++; $display("FAIL full_pre got ready=%b addr=%h want 0/7000", st_ready, dcache_address); end
    tick(); dcache_resp = 1'b0; if (sb.size() != 0) sb.pop_front();
    @(negedge clk);
    vec++; if (st_ready !== 1'b1 || sb.size() != 1) begin
      errs++; $display("FAIL full_no_accept got ready=%b queued=%0d want 1/1", st_ready, sb.size()); end
    vec++; if (sb.size() == 0 || dcache_write !== 1'b1 ||
               {dcache_address, dcache_wdata, dcache_wmask} !== {sb[0].a, sb[0].d, sb[0].m}) begin
      errs++; $display("FAIL full_next_head got write=%b %h/%h/%b", dcache_write, dcache_address, dcache_wdata, dcache_wmask); end
    tick(); st_valid = 1'b0;
    @(negedge clk);
    vec++; if (st_ready !== 1'b0 || sb.size() != 2) begin
      errs++; $display("FAIL full_refill got ready=%b queued=%0d want 0/2", st_ready, sb.size()); end
    for (int n = 0; n < 2; n++) begin
      vec++;
      if (sb.size() == 0 || dcache_write !== 1'b1 ||
          {dcache_address, dcache_wdata, dcache_wmask} !== {sb[0].a, sb[0].d, sb[0].m}) begin
        errs++; $display("FAIL full_drain%0d got write=%b %h/%h/%b", n, dcache_write, dcache_address, dcache_wdata, dcache_wmask); end
      tick(); dcache_resp = 1'b1;
      tick(); dcache_resp = 1'b0; if (sb.size() != 0) sb.pop_front();
      @(negedge clk);
    end
    vec++; if (buf_empty !== 1'b1 || dcache_write !== 1'b0) begin
      errs++; $display("FAIL full_empty got empty=%b write=%b want 1/0", buf_empty, dcache_write); end
  endtask

  task automatic test_ld_conflict();
    set_store(16'h5000, 16'hCAFE, 1'b0); tick();
    st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 16'h5001;
    @(negedge clk);
    vec++; if (ld_conflict !== 1'b1) begin
      errs++; $display("FAIL ld_hit got=%b want=1", ld_conflict); end
    ld_addr = 16'h5002; #1;
    vec++; if (ld_conflict !== 1'b0) begin
      errs++; $display("FAIL ld_miss got=%b want=0", ld_conflict); end
    ld_addr = 16'h5001;
    tick(); dcache_resp = 1'b1;
    @(negedge clk);
    vec++; if (ld_conflict !== 1'b1 || dcache_write !== 1'b1) begin
      errs++; $display("FAIL ld_hit_writing got conflict=%b write=%b want 1/1", ld_conflict, dcache_write); end
    tick(); dcache_resp = 1'b0; if (sb.size() != 0) sb.pop_front();
    @(negedge clk);
    vec++; if (ld_conflict !== 1'b0) begin
      errs++; $display("FAIL ld_after_pop got=%b want=0", ld_conflict); end
    ld_valid = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int seen = 0;
    set_store(16'h8000, 16'hAAAA, 1'b0); tick();
    set_store(16'h8002, 16'hBBBB, 1'b0); tick();
    st_valid = 1'b0;
    @(negedge clk);
    vec++; if (dcache_write !== 1'b1) begin
      errs++; $display("FAIL rst_pre got write=%b want 1", dcache_write); end
    #2 rst_n = 1'b0;
    #1;
    vec++; if ({dcache_write, buf_empty, st_ready} !== 3'b011 || dcache_address !== 16'h0) begin
      errs++; $display("FAIL rst_async got write=%b empty=%b ready=%b addr=%h", dcache_write, buf_empty, st_ready, dcache_address); end
    sb.delete();
    tick(); rst_n = 1'b1;
    repeat (6) begin @(negedge clk); if (dcache_write) seen++; end
    vec++; if (seen != 0 || buf_empty !== 1'b1) begin
      errs++; $display("FAIL rst_no_write got writes=%0d empty=%b want 0/1", seen, buf_empty); end
  endtask

  task automatic test_idle_resp();
    tick(); dcache_resp = 1'b1;
    tick(); dcache_resp = 1'b0;
    @(negedge clk);
    vec++; if ({dcache_write, buf_empty, st_ready} !== 3'b011 || {dcache_address, dcache_wmask} !== 18'h0) begin
      errs++; $display("FAIL idle_resp got write=%b empty=%b ready=%b", dcache_write, buf_empty, st_ready); end
    tick(); set_store(16'h6003, 16'h9876, 1'b0);
    tick(); st_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    vec++; if (dcache_write !== 1'b1 || dcache_address !== 16'h6002 || dcache_wmask !== 2'b11 ||
               sb.size() == 0 || dcache_wdata !== sb[0].d) begin
      errs++; $display("FAIL stw_odd got write=%b %h/%h/%b want 6002/9876/11", dcache_write, dcache_address, dcache_wdata, dcache_wmask); end
    tick(); dcache_resp = 1'b1;
    tick(); dcache_resp = 1'b0; if (sb.size() != 0) sb.pop_front();
    @(negedge clk);
    vec++; if (buf_empty !== 1'b1) begin
      errs++; $display("FAIL stw_odd_empty got=%b want=1", buf_empty); end
  endtask

  initial begin
    test_reset();
    test_stb_basic();
    test_back_to_back();
    test_full_pop_push();
    test_ld_conflict();
    test_reset_mid_write();
    test_idle_resp();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
